miti_video_capture: RTL

- Sits directly downstream of the MITI PLL pixel-clock divider. Consumes its recovered pixel clock together with the Model III video/sync inputs.
- Samples one monochrome pixel per recovered pixel-clock rising edge, packs 8 pixels per byte and writes the active 512x192 window into the dual-port frame buffer.
- The VGA scan-out side reads that frame buffer.
- All logic runs on the single system clock; pix_clk is treated as a level to be edge-detected, never as a clock.

---
 rtl/miti_video_pkg.sv | 21 ++
 rtl/miti_sync_edge.sv | 33 +++
 rtl/miti_video_capture.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/miti_video_pkg.sv
// Shared definitions for the MITI video capture block: FSM state encoding,
// default 512x192 monochrome geometry and the bytes-per-line derivation.
package miti_video_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_V_SKIP,
        ST_H_SKIP,
        ST_ACTIVE,
        ST_LINE_END
    } cap_state_e;

    function automatic int bytes_per_line(input int h_active);
        return h_active / 8;
    endfunction

    localparam int DEF_H_ACTIVE       = 512;
    localparam int DEF_V_ACTIVE       = 192;
    localparam int DEF_BYTES_PER_LINE = bytes_per_line(DEF_H_ACTIVE);

endpackage

// File: rtl/miti_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, with rise/fall pulses
// derived from the synchronized value and its one-cycle-delayed copy.
module miti_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // NOTE: non-blocking assignments so each stage captures the previous stage's old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/miti_video_capture.sv
// Captures the Model III active video window into a byte-wide frame buffer.
// Define MITI_VCAP_STATS_EN to add the err_count / last_lines statistics ports.
module miti_video_capture
    import miti_video_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int H_SKIP   = 96,
    parameter int V_SKIP   = 30,
    parameter int ADDR_W   = $clog2(DEF_BYTES_PER_LINE * DEF_V_ACTIVE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_clk,
    input  logic              video_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_done,
    output logic              capturing
`ifdef MITI_VCAP_STATS_EN
    ,
    output logic [7:0]        err_count,
    output logic [9:0]        last_lines
`endif
);

    localparam int BPL   = bytes_per_line(H_ACTIVE);
    localparam int PIX_W = $clog2(H_ACTIVE);
    localparam int CNT_W = 16;

    logic video_s, hs_fall, vs_fall, strobe, pix_prev_q;
    logic hs_level_unused, hs_rise_unused, vs_level_unused, vs_rise_unused;
    logic vid_rise_unused, vid_fall_unused;

    miti_sync_edge u_sync_hs (
        .clk(clk), .reset(reset), .async_i(hsync_in),
        .level_o(hs_level_unused), .rise_o(hs_rise_unused), .fall_o(hs_fall)
    );
    miti_sync_edge u_sync_vs (
        .clk(clk), .reset(reset), .async_i(vsync_in),
        .level_o(vs_level_unused), .rise_o(vs_rise_unused), .fall_o(vs_fall)
    );
    miti_sync_edge u_sync_vid (
        .clk(clk), .reset(reset), .async_i(video_in),
        .level_o(video_s), .rise_o(vid_rise_unused), .fall_o(vid_fall_unused)
    );

    assign strobe = pix_clk & ~pix_prev_q;

    cap_state_e        state_q, state_d;
    logic [CNT_W-1:0]  hcount_q, hcount_d, vcount_q, vcount_d, line_q, line_d;
    logic [CNT_W-1:0]  hcount_inc, vcount_inc, line_inc;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d, base_inc;
    logic [7:0]        shift_q, shift_d;
    logic              wr_en_q, wr_en_d, frame_done_q, frame_done_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;

    assign hcount_inc = hcount_q + CNT_W'(1);
    assign vcount_inc = vcount_q + CNT_W'(1);
    assign line_inc   = line_q + CNT_W'(1);
    assign base_inc   = line_base_q + ADDR_W'(BPL);

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        hcount_d     = hcount_q;
        vcount_d     = vcount_q;
        line_d       = line_q;
        pix_d        = pix_q;
        line_base_d  = line_base_q;
        shift_d      = shift_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;

        if (vs_fall) begin
            // Start of a new frame; any frame in progress is abandoned.
            state_d     = ST_V_SKIP;
            hcount_d    = '0;
            vcount_d    = '0;
            line_d      = '0;
            pix_d       = '0;
            line_base_d = '0;
            shift_d     = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                end
                ST_V_SKIP: begin
                    if (hs_fall) begin
                        if (32'(vcount_inc) >= V_SKIP) begin
                            state_d  = ST_H_SKIP;
                            hcount_d = '0;
                        end else begin
                            vcount_d = vcount_inc;
                        end
                    end
                end
                ST_H_SKIP, ST_ACTIVE: begin
                    if (hs_fall) begin
                        // Short line: drop the partial byte but still consume the line.
                        line_d      = line_inc;
                        line_base_d = base_inc;
                        hcount_d    = '0;
                        pix_d       = '0;
                        shift_d     = '0;
                        if (32'(line_inc) >= V_ACTIVE) begin
                            state_d      = ST_IDLE;
                            frame_done_d = 1'b1;
                        end else begin
                            state_d = ST_H_SKIP;
                        end
                    end else if (strobe) begin
                        if (state_q == ST_H_SKIP) begin
                            if (32'(hcount_inc) >= H_SKIP) begin
                                state_d = ST_ACTIVE;
                                pix_d   = '0;
                            end else begin
                                hcount_d = hcount_inc;
                            end
                        end else begin
                            shift_d = {shift_q[6:0], video_s};
                            pix_d   = pix_q + PIX_W'(1);
                            if (pix_q[2:0] == 3'b111) begin
                                wr_en_d   = 1'b1;
                                wr_data_d = {shift_q[6:0], video_s};
                                wr_addr_d = line_base_q + ADDR_W'(pix_q >> 3);
                            end
                            if (32'(pix_q) == H_ACTIVE - 1) begin
                                state_d     = ST_LINE_END;
                                line_d      = line_inc;
                                line_base_d = base_inc;
                            end
                        end
                    end
                end
                ST_LINE_END: begin
                    if (32'(line_q) >= V_ACTIVE) begin
                        state_d      = ST_IDLE;
                        frame_done_d = 1'b1;
                    end else if (hs_fall) begin
                        state_d  = ST_H_SKIP;
                        hcount_d = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pix_prev_q   <= 1'b0;
            hcount_q     <= '0;
            vcount_q     <= '0;
            line_q       <= '0;
            pix_q        <= '0;
            line_base_q  <= '0;
            shift_q      <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_prev_q   <= pix_clk;
            hcount_q     <= hcount_d;
            vcount_q     <= vcount_d;
            line_q       <= line_d;
            pix_q        <= pix_d;
            line_base_q  <= line_base_d;
            shift_q      <= shift_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign capturing  = (state_q == ST_H_SKIP) || (state_q == ST_ACTIVE) ||
                        (state_q == ST_LINE_END);

`ifdef MITI_VCAP_STATS_EN
    logic       short_line, abort;
    logic [7:0] err_q;
    logic [9:0] hs_cnt_q, last_lines_q;

    assign abort      = vs_fall && (state_q != ST_IDLE);
    assign short_line = !vs_fall && hs_fall &&
                        ((state_q == ST_H_SKIP) || (state_q == ST_ACTIVE));

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q        <= '0;
            hs_cnt_q     <= '0;
            last_lines_q <= '0;
        end else begin
            if ((short_line || abort) && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end
            if (vs_fall) begin
                last_lines_q <= hs_cnt_q;
                hs_cnt_q     <= '0;
            end else if (hs_fall && (hs_cnt_q != 10'h3FF)) begin
                hs_cnt_q <= hs_cnt_q + 10'd1;
            end
        end
    end

    assign err_count  = err_q;
    assign last_lines = last_lines_q;
`endif

endmodule
